// File: rtl/draw_source_arbiter.sv
// draw_source_arbiter
//
// Receiving end of the draw-source write bus. On every frame_start it polls
// each draw source in ascending ID order. A polled source gets
// write_source_sel and write_awaited. The arbiter then captures the pixel
// stream that the source returns on the shared write_* lines. Every accepted
// pixel that is in bounds and not transparent becomes one registered
// framebuffer write.
//
// Ports
//   clk, reset          : system clock; synchronous active-high reset
//   frame_start         : one-cycle pulse, back buffer ready for drawing
//   write_source_sel    : ID of the currently addressed source
//   write_awaited       : arbiter ready for the addressed source to stream
//   write_active        : addressed source is streaming, one pixel per cycle
//   write_color_data    : pixel color
//   write_transparent   : current pixel must not be written
//   write_x_addr        : pixel x coordinate
//   write_y_addr        : pixel y coordinate
//   fb_we/fb_x/fb_y/fb_data : registered framebuffer write port
//   busy                : high whenever the arbiter is not idle
//   frame_done          : one-cycle pulse, all sources serviced
//   frame_overrun       : one-cycle pulse, frame_start arrived while busy
//   pixels_written      : fb_we count for the current/last frame, saturating
//   sources_skipped     : select timeouts in the current/last frame
module draw_source_arbiter #(
    parameter int NUM_SOURCES       = 4,
    parameter int SOURCE_SEL_ADDRW  = 3,
    parameter int DRAW_WIDTH        = 160,
    parameter int DRAW_WIDTH_ADDRW  = 8,
    parameter int DRAW_HEIGHT       = 120,
    parameter int DRAW_HEIGHT_ADDRW = 7,
    parameter int COLOR_DEPTH       = 9,
    parameter int SELECT_TIMEOUT    = 1023
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          frame_start,
    output logic [SOURCE_SEL_ADDRW-1:0]   write_source_sel,
    output logic                          write_awaited,
    input  logic                          write_active,
    input  logic [COLOR_DEPTH-1:0]        write_color_data,
    input  logic                          write_transparent,
    input  logic [DRAW_WIDTH_ADDRW-1:0]   write_x_addr,
    input  logic [DRAW_HEIGHT_ADDRW-1:0]  write_y_addr,
    output logic                          fb_we,
    output logic [DRAW_WIDTH_ADDRW-1:0]   fb_x,
    output logic [DRAW_HEIGHT_ADDRW-1:0]  fb_y,
    output logic [COLOR_DEPTH-1:0]        fb_data,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          frame_overrun,
    output logic [15:0]                   pixels_written,
    output logic [SOURCE_SEL_ADDRW:0]     sources_skipped
);

    localparam int TO_W = (SELECT_TIMEOUT < 1) ? 1 : $clog2(SELECT_TIMEOUT + 1);
    localparam int SKW  = SOURCE_SEL_ADDRW + 1;
    localparam logic [SOURCE_SEL_ADDRW-1:0] LAST_IDX = SOURCE_SEL_ADDRW'(NUM_SOURCES - 1);
    localparam logic [TO_W-1:0]             TO_LIMIT = TO_W'(SELECT_TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_STREAM,
        ST_NEXT,
        ST_DONE
    } state_t;

    state_t                        state, state_nx;
    logic [SOURCE_SEL_ADDRW-1:0]   idx, idx_nx;
    logic [TO_W-1:0]               to_cnt, to_cnt_nx;
    logic                          bus_active;
    logic                          timeout;
    logic                          capture;

    logic [SOURCE_SEL_ADDRW-1:0]   sel_nx;
    logic                          awaited_nx;
    logic                          busy_nx;
    logic                          done_nx;
    logic                          overrun_nx;
    logic                          vld_p0;

    logic                          vld_p1;
    logic [DRAW_WIDTH_ADDRW-1:0]   x_p1;
    logic [DRAW_HEIGHT_ADDRW-1:0]  y_p1;
    logic [COLOR_DEPTH-1:0]        color_p1;
    logic [SOURCE_SEL_ADDRW-1:0]   sel_r;
    logic                          awaited_r;
    logic                          busy_r;
    logic                          done_r;
    logic                          overrun_r;
    logic [15:0]                   pix_cnt_r;
    logic [SKW-1:0]                skip_cnt_r;

    function automatic logic pix_ok(
        input logic                         transp,
        input logic [DRAW_WIDTH_ADDRW-1:0]  x,
        input logic [DRAW_HEIGHT_ADDRW-1:0] y
    );
        return !transp && (int'(x) < DRAW_WIDTH) && (int'(y) < DRAW_HEIGHT);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // An undriven bus (X/Z) must read as "not streaming", so only an explicit 1 counts.
    always_comb begin
        bus_active = 1'b0;
        if (write_active == 1'b1) begin
            bus_active = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            idx    <= '0;
            to_cnt <= '0;
        end else begin
            state  <= state_nx;
            idx    <= idx_nx;
            to_cnt <= to_cnt_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        to_cnt_nx = to_cnt;
        timeout   = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (frame_start) begin
                    state_nx  = ST_SELECT;
                    idx_nx    = '0;
                    to_cnt_nx = '0;
                end
            end
            ST_SELECT: begin
                to_cnt_nx = to_cnt + TO_W'(1);
                if (bus_active) begin
                    // The first pixel arrives in the same cycle as the handshake.
                    capture  = 1'b1;
                    state_nx = ST_STREAM;
                end else if (to_cnt + TO_W'(1) == TO_LIMIT) begin
                    timeout  = 1'b1;
                    state_nx = ST_NEXT;
                end
            end
            ST_STREAM: begin
                if (bus_active) begin
                    capture = 1'b1;
                end else begin
                    state_nx = ST_NEXT;
                end
            end
            ST_NEXT: begin
                to_cnt_nx = '0;
                if (idx == LAST_IDX) begin
                    state_nx = ST_DONE;
                end else begin
                    idx_nx   = idx + SOURCE_SEL_ADDRW'(1);
                    state_nx = ST_SELECT;
                end
            end
            ST_DONE: begin
                idx_nx   = '0;
                state_nx = ST_IDLE;
            end
            default: begin
                idx_nx   = '0;
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Output logic: the values computed here are registered, so every output
    // reflects the state that the FSM has just entered.
    always_comb begin
        sel_nx     = '0;
        awaited_nx = (state_nx == ST_SELECT);
        busy_nx    = (state_nx != ST_IDLE);
        done_nx    = (state_nx == ST_DONE);
        overrun_nx = frame_start && (state != ST_IDLE);
        vld_p0     = capture && pix_ok(write_transparent, write_x_addr, write_y_addr);
        if ((state_nx == ST_SELECT) || (state_nx == ST_STREAM) || (state_nx == ST_NEXT)) begin
            sel_nx = idx_nx;
        end
    end

    // Stage p0 -> p1: captured pixel becomes the framebuffer write
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_r      <= '0;
            awaited_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            overrun_r  <= 1'b0;
            vld_p1     <= 1'b0;
            x_p1       <= '0;
            y_p1       <= '0;
            color_p1   <= '0;
            pix_cnt_r  <= '0;
            skip_cnt_r <= '0;
        end else begin
            sel_r     <= sel_nx;
            awaited_r <= awaited_nx;
            busy_r    <= busy_nx;
            done_r    <= done_nx;
            overrun_r <= overrun_nx;
            vld_p1    <= vld_p0;
            if (vld_p0) begin
                x_p1     <= write_x_addr;
                y_p1     <= write_y_addr;
                color_p1 <= write_color_data;
            end
            if ((state == ST_IDLE) && frame_start) begin
                pix_cnt_r  <= '0;
                skip_cnt_r <= '0;
            end else begin
                if (vld_p0) begin
                    pix_cnt_r <= sat_inc16(pix_cnt_r);
                end
                if (timeout) begin
                    skip_cnt_r <= skip_cnt_r + SKW'(1);
                end
            end
        end
    end

    assign write_source_sel = sel_r;
    assign write_awaited    = awaited_r;
    assign busy             = busy_r;
    assign frame_done       = done_r;
    assign frame_overrun    = overrun_r;
    assign fb_we            = vld_p1;
    assign fb_x             = x_p1;
    assign fb_y             = y_p1;
    assign fb_data          = color_p1;
    assign pixels_written   = pix_cnt_r;
    assign sources_skipped  = skip_cnt_r;

endmodule
